seven_seg_scanner: RTL and testbench

- Downstream display stage for the counter blocks.
- Takes a 16-bit value (four hex nibbles) and time-multiplexes it across a 4-digit seven-segment display. It drives one-hot digit enables and active-high segments.
- New values are double-buffered and applied only at frame boundaries, so a displayed frame never tears.
- Replaces the fixed single-digit enable used by the counter tops.

---
 rtl/seven_seg_pkg.sv | 41 ++++
 rtl/seven_seg_scanner_hex_to_seg.sv | 32 +++
 rtl/seven_seg_scanner.sv | 108 ++++++++++
 tb/tb_seven_seg_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, types and helpers for the seven-segment display blocks.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

    typedef logic [IDX_W-1:0] digit_idx_t;

    // Value and decimal points travel together through pending/display.
    typedef struct packed {
        logic [VALUE_W-1:0]    value;
        logic [NUM_DIGITS-1:0] dp;
    } disp_word_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        digit_onehot = NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to seven-segment pattern decoder; reusable by other display tops.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-aligned double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned         REFRESH_DIV = 50000,
    parameter logic [NUM_DIGITS-1:0] DP_MASK_RST = 4'b0000
) (
    input  logic                  in_clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic [NUM_DIGITS-1:0] dp,
    input  logic                  load,
    output logic [SEG_W:0]        Seven_Seg,
    output logic [NUM_DIGITS-1:0] digit,
    output logic                  frame
);

    localparam int unsigned   CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam digit_idx_t    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam disp_word_t    WORD_RST = '{value: '0, dp: DP_MASK_RST};

    logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
    digit_idx_t            idx_q, idx_d;
    disp_word_t            pend_q, pend_d;
    disp_word_t            disp_q, disp_d;
    logic [SEG_W:0]        seg_q, seg_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic                  frame_q, frame_d;

    logic                  tick_c;
    logic                  boundary_c;
    disp_word_t            in_word_c;
    logic [NIBBLE_W-1:0]   nibble_c;
    logic [SEG_W-1:0]      pattern_c;
    logic                  blank_c;

    // Prescaler, digit index and frame-aligned buffer transfer.
    always_comb begin
        tick_c     = (tick_cnt_q == CNT_MAX);
        boundary_c = tick_c && (idx_q == IDX_LAST);
        in_word_c  = '{value: value, dp: dp};

        tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
        idx_d      = tick_c ? idx_q + IDX_W'(1) : idx_q;
        pend_d     = load ? in_word_c : pend_q;
        disp_d     = disp_q;
        if (boundary_c) begin
            // A load landing on the boundary cycle bypasses pending.
            disp_d = load ? in_word_c : pend_q;
        end
        frame_d    = boundary_c;
    end

    assign nibble_c = disp_q.value[{idx_q, 2'b00} +: NIBBLE_W];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble_c),
        .seg_c  (pattern_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when every nibble at or above this digit is zero; digit 0 always shows.
    always_comb begin
        blank_c = 1'b0;
        case (idx_q)
            2'd1:    blank_c = (disp_q.value[15:4]  == 12'h000);
            2'd2:    blank_c = (disp_q.value[15:8]  == 8'h00);
            2'd3:    blank_c = (disp_q.value[15:12] == 4'h0);
            default: blank_c = 1'b0;
        endcase
    end
`else
    assign blank_c = 1'b0;
`endif

    // Output stage: one cycle behind idx/display.
    always_comb begin
        digit_d = digit_onehot(idx_q);
        seg_d   = {disp_q.dp[idx_q], blank_c ? SEG_BLANK : pattern_c};
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            idx_q      <= '0;
            pend_q     <= WORD_RST;
            disp_q     <= WORD_RST;
            seg_q      <= '0;
            digit_q    <= '0;
            frame_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            seg_q      <= seg_d;
            digit_q    <= digit_d;
            frame_q    <= frame_d;
        end
    end

    assign Seven_Seg = seg_q;
    assign digit     = digit_q;
    assign frame     = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner with REFRESH_DIV=4.
module tb_seven_seg_scanner;

    logic        in_clk = 1'b0;
    logic        rst    = 1'b1;
    logic [15:0] value  = 16'h0000;
    logic [3:0]  dp     = 4'b0000;
    logic        load   = 1'b0;
    logic [7:0]  Seven_Seg;
    logic [3:0]  digit;
    logic        frame;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] cap_seg [16];
    logic [3:0] cap_dig [16];
    logic       cap_frm [16];

    seven_seg_scanner #(.REFRESH_DIV(4), .DP_MASK_RST(4'b0000)) dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .value     (value),
        .dp        (dp),
        .load      (load),
        .Seven_Seg (Seven_Seg),
        .digit     (digit),
        .frame     (frame)
    );

    always #5 in_clk = ~in_clk;

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wait_frame(output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (frame !== 1'b1 && steps < 64);
    endtask

    // Sample one full scan: 16 cycles after a frame edge, ending on the next frame edge.
    task automatic capture_scan();
        for (int i = 0; i < 16; i++) begin
            step();
            cap_seg[i] = Seven_Seg;
            cap_dig[i] = digit;
            cap_frm[i] = frame;
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_seg [4];
        rst = 1'b1;
        repeat (3) step();
        n_cmp++; if (digit !== 4'b0000) begin n_fail++; $display("FAIL reset_digit got %b want 0000", digit); end
        n_cmp++; if (Seven_Seg !== 8'h00) begin n_fail++; $display("FAIL reset_seg got %h want 00", Seven_Seg); end
        n_cmp++; if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b want 0", frame); end
        rst = 1'b0;
        exp_seg = '{8'h3F, 8'h3F, 8'h3F, 8'h3F};
        capture_scan();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (cap_seg[i] !== exp_seg[i/4]) begin n_fail++; $display("FAIL reset_scan_seg[%0d] got %h want %h", i, cap_seg[i], exp_seg[i/4]); end
            n_cmp++; if (cap_dig[i] !== 4'(4'b0001 << (i/4))) begin n_fail++; $display("FAIL reset_scan_dig[%0d] got %b want %b", i, cap_dig[i], 4'(4'b0001 << (i/4))); end
            n_cmp++; if (cap_frm[i] !== (i == 15)) begin n_fail++; $display("FAIL reset_scan_frame[%0d] got %b want %b", i, cap_frm[i], (i == 15)); end
        end
    endtask

    task automatic test_load_midframe();
        logic [7:0] exp_seg [4];
        int steps;
        repeat (2) step();
        value = 16'h1A2F; dp = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        n_cmp++; if (digit !== 4'b0001) begin n_fail++; $display("FAIL mid_digit got %b want 0001", digit); end
        n_cmp++; if (Seven_Seg !== 8'h3F) begin n_fail++; $display("FAIL mid_unchanged got %h want 3F", Seven_Seg); end
        wait_frame(steps);
        n_cmp++; if (steps != 13 || frame !== 1'b1) begin n_fail++; $display("FAIL mid_frame_delay got %0d want 13", steps); end
        exp_seg = '{8'h71, 8'h5B, 8'hF7, 8'h06};
        capture_scan();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (cap_seg[i] !== exp_seg[i/4]) begin n_fail++; $display("FAIL load_scan_seg[%0d] got %h want %h", i, cap_seg[i], exp_seg[i/4]); end
            n_cmp++; if (cap_dig[i] !== 4'(4'b0001 << (i/4))) begin n_fail++; $display("FAIL load_scan_dig[%0d] got %b want %b", i, cap_dig[i], 4'(4'b0001 << (i/4))); end
            n_cmp++; if (cap_frm[i] !== (i == 15)) begin n_fail++; $display("FAIL load_scan_frame[%0d] got %b want %b", i, cap_frm[i], (i == 15)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seg [4];
        int steps;
        repeat (2) step();
        value = 16'h1111; dp = 4'b0000; load = 1'b1;
        step();
        value = 16'h2222;
        step();
        load = 1'b0;
        wait_frame(steps);
        n_cmp++; if (frame !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_timeout got %b want 1", frame); end
        exp_seg = '{8'h5B, 8'h5B, 8'h5B, 8'h5B};
        capture_scan();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (cap_seg[i] !== exp_seg[i/4]) begin n_fail++; $display("FAIL b2b_scan_seg[%0d] got %h want %h", i, cap_seg[i], exp_seg[i/4]); end
            n_cmp++; if (cap_dig[i] !== 4'(4'b0001 << (i/4))) begin n_fail++; $display("FAIL b2b_scan_dig[%0d] got %b want %b", i, cap_dig[i], 4'(4'b0001 << (i/4))); end
        end
    endtask

    task automatic test_boundary_load();
        logic [7:0] exp_seg [4];
        repeat (15) step();
        value = 16'h3333; dp = 4'b0001; load = 1'b1;
        step();
        load = 1'b0;
        n_cmp++; if (frame !== 1'b1) begin n_fail++; $display("FAIL bnd_frame got %b want 1", frame); end
        exp_seg = '{8'hCF, 8'h4F, 8'h4F, 8'h4F};
        capture_scan();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (cap_seg[i] !== exp_seg[i/4]) begin n_fail++; $display("FAIL bnd_scan_seg[%0d] got %h want %h", i, cap_seg[i], exp_seg[i/4]); end
            n_cmp++; if (cap_frm[i] !== (i == 15)) begin n_fail++; $display("FAIL bnd_scan_frame[%0d] got %b want %b", i, cap_frm[i], (i == 15)); end
        end
    endtask

    task automatic test_reset_midframe();
        int guard;
        repeat (2) step();
        value = 16'h4444; dp = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        guard = 0;
        while (digit !== 4'b0100 && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++; if (digit !== 4'b0100) begin n_fail++; $display("FAIL rstmid_reach_digit2 got %b want 0100", digit); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (digit !== 4'b0000) begin n_fail++; $display("FAIL rstmid_digit got %b want 0000", digit); end
        n_cmp++; if (Seven_Seg !== 8'h00) begin n_fail++; $display("FAIL rstmid_seg got %h want 00", Seven_Seg); end
        n_cmp++; if (frame !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame got %b want 0", frame); end
        for (int pass = 0; pass < 2; pass++) begin
            capture_scan();
            for (int i = 0; i < 16; i++) begin
                n_cmp++; if (cap_seg[i] !== 8'h3F) begin n_fail++; $display("FAIL rstmid_scan%0d_seg[%0d] got %h want 3F", pass, i, cap_seg[i]); end
                n_cmp++; if (cap_dig[i] !== 4'(4'b0001 << (i/4))) begin n_fail++; $display("FAIL rstmid_scan%0d_dig[%0d] got %b want %b", pass, i, cap_dig[i], 4'(4'b0001 << (i/4))); end
                n_cmp++; if (cap_frm[i] !== (i == 15)) begin n_fail++; $display("FAIL rstmid_scan%0d_frame[%0d] got %b want %b", pass, i, cap_frm[i], (i == 15)); end
            end
        end
    endtask

    task automatic test_blank();
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        int steps;
`ifdef LEADING_ZERO_BLANK_EN
        exp_a = '{8'h3F, 8'h6D, 8'h00, 8'h00};
        exp_b = '{8'h3F, 8'h00, 8'h00, 8'h00};
`else
        exp_a = '{8'h3F, 8'h6D, 8'h3F, 8'h3F};
        exp_b = '{8'h3F, 8'h3F, 8'h3F, 8'h3F};
`endif
        step();
        value = 16'h0050; dp = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        wait_frame(steps);
        n_cmp++; if (frame !== 1'b1) begin n_fail++; $display("FAIL blank_a_frame_timeout got %b want 1", frame); end
        capture_scan();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (cap_seg[i] !== exp_a[i/4]) begin n_fail++; $display("FAIL blank_0050_seg[%0d] got %h want %h", i, cap_seg[i], exp_a[i/4]); end
        end
        step();
        value = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        wait_frame(steps);
        n_cmp++; if (frame !== 1'b1) begin n_fail++; $display("FAIL blank_b_frame_timeout got %b want 1", frame); end
        capture_scan();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (cap_seg[i] !== exp_b[i/4]) begin n_fail++; $display("FAIL blank_0000_seg[%0d] got %h want %h", i, cap_seg[i], exp_b[i/4]); end
        end
    endtask

    task automatic test_long_run();
        logic [3:0] prev_dig;
        int         run_len;
        int         last_frame;
        bit         first_run;
        prev_dig   = digit;
        run_len    = 0;
        first_run  = 1'b1;
        last_frame = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            n_cmp++; if ($onehot(digit) !== 1'b1) begin n_fail++; $display("FAIL long_onehot[%0d] got %b want one-hot", i, digit); end
            if (digit === prev_dig) begin
                run_len++;
            end else begin
                if (!first_run) begin
                    n_cmp++; if (run_len != 4) begin n_fail++; $display("FAIL long_run_len[%0d] got %0d want 4", i, run_len); end
                end
                first_run = 1'b0;
                prev_dig  = digit;
                run_len   = 1;
            end
            if (frame === 1'b1) begin
                n_cmp++; if (i - last_frame != 16) begin n_fail++; $display("FAIL long_frame_period[%0d] got %0d want 16", i, i - last_frame); end
                last_frame = i;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_back_to_back();
        test_boundary_load();
        test_reset_midframe();
        test_blank();
        test_long_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
